i2c_bus_arb: RTL and testbench
==============================

I2C_BUS_ARB -- requirements
Module: i2c_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20000: i2c_clk cycles allowed in BUSY before abort.
REQ-002 SHALL have port clk, input, 1: i2c_clk domain clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port req, input, 2: per-requester request level (bit0 RTC ctrl, bit1 EEPROM ctrl).
REQ-005 SHALL have port req_wr_en, input, 2: per-requester write command.
REQ-006 SHALL have port req_rd_en, input, 2: per-requester read command.
REQ-007 SHALL have port req_addr, input, 32: per-requester 16-bit byte address, packed {req1, req0}.
REQ-008 SHALL have port req_wr_data, input, 16: per-requester write byte, packed {req1, req0}.
REQ-009 SHALL have port grant, output, 2: one-hot owner of the I2C master, zero when idle.
REQ-010 SHALL have port done, output, 2: one-cycle completion pulse to the owner.
REQ-011 SHALL have port err, output, 1: qualifies done; 1 = timeout or illegal command.
REQ-012 SHALL have port rsp_data, output, 8: read byte, valid while done is high.
REQ-013 SHALL have ports i2c_start, wr_en, rd_en (output, 1), byte_addr (output, 16), wr_data (output, 8): to the I2C master.
REQ-014 SHALL have ports i2c_end (input, 1) and rd_data (input, 8): from the I2C master.

Function
REQ-015 SHALL implement states IDLE, ISSUE, BUSY, DONE.
REQ-016 IDLE: any req bit sampled high SHALL select the owner, register grant, wr_en, rd_en, byte_addr and wr_data from that requester, and move to ISSUE.
REQ-017 Owner selection SHALL be round-robin: the requester not most recently served wins a simultaneous request; after reset requester 0 has priority.
REQ-018 ISSUE: i2c_start SHALL be high for exactly this one cycle; next state BUSY.
REQ-019 Latency SHALL be: req sampled at edge k -> i2c_start high in cycle k+1.
REQ-020 byte_addr, wr_data, wr_en and rd_en SHALL stay stable from ISSUE through DONE; later changes on the owner's inputs SHALL be ignored.
REQ-021 BUSY: i2c_end sampled at edge m SHALL give state DONE in cycle m+1, with done[owner]=1, err=0, and rsp_data=rd_data captured at edge m (0 for writes).
REQ-022 BUSY: if i2c_end is still absent after TIMEOUT cycles, the block SHALL enter DONE with err=1 and rsp_data=0.
REQ-023 DONE SHALL last one cycle; it then clears grant, wr_en and rd_en, records the owner as last-served, and returns to IDLE.
REQ-024 Requesters hold req until done and drop it by the cycle after done; IDLE SHALL be entered no earlier than one cycle after DONE, so a released request is never re-granted.
REQ-025 req_wr_en and req_rd_en both high SHALL execute a write (rd_en=0).
REQ-026 Both low SHALL skip ISSUE/BUSY, emit no i2c_start, and go IDLE -> DONE with err=1.
REQ-027 i2c_end in IDLE, ISSUE or DONE SHALL be ignored.
REQ-028 A non-owner's req SHALL stay pending without effect until IDLE.
REQ-029 The timeout counter SHALL be wide enough for TIMEOUT without wrap and SHALL clear on every BUSY entry.

Reset
REQ-030 rst SHALL force: state IDLE; grant, done, err, i2c_start, wr_en and rd_en to 0; byte_addr, wr_data and rsp_data to 0; priority to requester 0; timeout counter to 0.
REQ-031 rst mid-transaction SHALL abort silently (no done pulse); the I2C master is reset by the same rst.

Structure
REQ-032 A shared package SHALL hold the state encodings, requester indices (RTC=0, EEPROM=1) and the TIMEOUT default.
REQ-033 Round-robin selection SHALL be a sub-module i2c_rr_pick (inputs req[1:0], last; outputs one-hot pick); everything else is inline.

Verification
REQ-034 Single read: req=01, rd_en, addr 0x0002; i2c_end with rd_data=0x59 -> i2c_start in cycle k+1, byte_addr=0x0002, done=01, err=0, rsp_data=0x59.
REQ-035 Simultaneous: req=11 after reset -> requester 0 served first, then requester 1 with no intervening idle grant; repeat -> order alternates to 1, then 0.
REQ-036 Timeout with TIMEOUT=16: no i2c_end -> done pulse exactly 16 cycles after BUSY entry, err=1, rsp_data=0x00.
REQ-037 Illegal command: req_wr_en=req_rd_en=0 on requester 1 -> no i2c_start, done=10, err=1.
REQ-038 Reset mid-BUSY: rst asserted, then i2c_end pulsed -> all outputs 0, no done; next request is served normally.
REQ-039 Stability: owner changes req_addr to 0x00FF during BUSY -> byte_addr keeps its original 0x0008 until DONE.

Source files
------------

// File: rtl/i2c_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// i2c_bus_arb_pkg
//   Shared definitions for the two-requester I2C master arbiter: FSM state
//   encoding, requester indices and the default BUSY timeout.
// -----------------------------------------------------------------------------
package i2c_bus_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Requester indices into every per-requester bus.
    localparam int unsigned REQ_RTC    = 0;
    localparam int unsigned REQ_EEPROM = 1;
    localparam int unsigned NUM_REQ    = 2;

    // i2c_clk cycles allowed in BUSY before the transfer is aborted.
    localparam int unsigned TIMEOUT_DEFAULT = 20000;

endpackage

// File: rtl/i2c_rr_pick.sv
// -----------------------------------------------------------------------------
// i2c_rr_pick
//   Two-way round-robin owner selection.
//   Ports:
//     req  [1:0]  request levels (bit0 RTC, bit1 EEPROM)
//     last        index of the most recently served requester
//     pick [1:0]  one-hot winner, zero when nobody requests
// -----------------------------------------------------------------------------
module i2c_rr_pick
    import i2c_bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] pick
);

    always_comb begin
        // NOTE: a default assignment ahead of every branch keeps this purely
        // combinational; a path that leaves pick unassigned would infer a latch.
        pick = '0;
        if (req[REQ_RTC] && req[REQ_EEPROM]) begin
            // Contention: whoever was not served last wins.
            if (last == 1'(REQ_RTC))
                pick[REQ_EEPROM] = 1'b1;
            else
                pick[REQ_RTC] = 1'b1;
        end else begin
            // Zero or one requester: the request vector is already one-hot.
            pick = req;
        end
    end

endmodule

// File: rtl/i2c_bus_arb.sv
// -----------------------------------------------------------------------------
// i2c_bus_arb
//   Shares one I2C byte master between an RTC controller (requester 0) and an
//   EEPROM controller (requester 1). The winner's command is latched in IDLE,
//   launched with a one-cycle i2c_start, and completed by i2c_end or a timeout.
//   Ports:
//     clk, rst                      i2c_clk domain, synchronous active-high reset
//     req, req_wr_en, req_rd_en     per-requester request level and command
//     req_addr, req_wr_data         per-requester address / write byte, {req1, req0}
//     grant, done, err, rsp_data    ownership, completion pulse, status, read byte
//     i2c_start, wr_en, rd_en,
//     byte_addr, wr_data            command to the I2C master
//     i2c_end, rd_data              completion and read byte from the I2C master
// -----------------------------------------------------------------------------
module i2c_bus_arb
    import i2c_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_wr_en,
    input  logic [NUM_REQ-1:0]   req_rd_en,
    input  logic [NUM_REQ*16-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [7:0]           rsp_data,
    output logic                 i2c_start,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [15:0]          byte_addr,
    output logic [7:0]           wr_data,
    input  logic                 i2c_end,
    input  logic [7:0]           rd_data
);

    // Wide enough to hold TIMEOUT itself, so the count never wraps.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_err;
    logic [7:0]           r_rsp_data;
    logic                 r_start;
    logic                 r_wr_en;
    logic                 r_rd_en;
    logic [15:0]          r_byte_addr;
    logic [7:0]           r_wr_data;
    logic                 r_owner;
    logic                 r_last;
    logic [CNT_W-1:0]     r_cnt;

    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_owner;
    logic                 w_sel_wr;
    logic                 w_sel_rd;
    logic [15:0]          w_sel_addr;
    logic [7:0]           w_sel_wdata;

    i2c_rr_pick u_rr_pick (
        .req  (req),
        .last (r_last),
        .pick (w_pick)
    );

    // Command of the requester that would win this cycle.
    assign w_owner     = w_pick[REQ_EEPROM];
    assign w_sel_wr    = req_wr_en[w_owner];
    assign w_sel_rd    = req_rd_en[w_owner];
    assign w_sel_addr  = w_owner ? req_addr[31:16]   : req_addr[15:0];
    assign w_sel_wdata = w_owner ? req_wr_data[15:8] : req_wr_data[7:0];

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the
        // values present before the edge, independent of statement order.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_rsp_data  <= '0;
            r_start     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_byte_addr <= '0;
            r_wr_data   <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'(REQ_EEPROM);   // requester 0 wins the first contention
            r_cnt       <= '0;
        end else begin
            // Pulse outputs fall back to zero unless a branch below raises them.
            r_start <= 1'b0;
            r_done  <= '0;
            r_err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_owner     <= w_owner;
                        r_grant     <= w_pick;
                        r_byte_addr <= w_sel_addr;
                        r_wr_data   <= w_sel_wdata;
                        r_wr_en     <= w_sel_wr;
                        r_rd_en     <= w_sel_rd & ~w_sel_wr;   // write wins a double command
                        r_rsp_data  <= '0;
                        if (w_sel_wr || w_sel_rd) begin
                            r_start <= 1'b1;
                            r_state <= ST_ISSUE;
                        end else begin
                            // No command at all: report an error without touching the bus.
                            r_done  <= w_pick;
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_BUSY;
                end

                ST_BUSY: begin
                    if (i2c_end) begin
                        r_done     <= r_grant;
                        r_rsp_data <= r_rd_en ? rd_data : 8'h00;
                        r_state    <= ST_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_done     <= r_grant;
                        r_err      <= 1'b1;
                        r_rsp_data <= 8'h00;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // One DONE cycle gives the owner time to drop req before IDLE samples again.
                    r_grant <= '0;
                    r_wr_en <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_last  <= r_owner;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign err       = r_err;
    assign rsp_data  = r_rsp_data;
    assign i2c_start = r_start;
    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign byte_addr = r_byte_addr;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_i2c_bus_arb
//   Self-checking bench for i2c_bus_arb with TIMEOUT=16. A transaction-level
//   model (timestamps of grant and completion) predicts every output each
//   cycle; directed scenarios pin it with literal expectations, then a
//   randomized phase drives both requesters, the master and occasional resets.
// -----------------------------------------------------------------------------
module tb_i2c_bus_arb;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_wr_en;
    logic [1:0]  req_rd_en;
    logic [31:0] req_addr;
    logic [15:0] req_wr_data;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        err;
    logic [7:0]  rsp_data;
    logic        i2c_start;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data;
    logic        i2c_end;
    logic [7:0]  rd_data;

    i2c_bus_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_wr_en   (req_wr_en),
        .req_rd_en   (req_rd_en),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .rsp_data    (rsp_data),
        .i2c_start   (i2c_start),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .byte_addr   (byte_addr),
        .wr_data     (wr_data),
        .i2c_end     (i2c_end),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // cyc numbers rising edges; "cycle n" is the interval after edge n.
    int          cyc      = 0;
    bit          m_active = 1'b0;   // a requester owns the master
    int          m_owner  = 0;
    int          m_last   = 1;
    bit          m_legal, m_wr, m_rd, m_err;
    logic [15:0] m_addr   = '0;
    logic [7:0]  m_wdata  = '0;
    logic [7:0]  m_rsp    = '0;
    int          m_g      = 0;      // edge at which the owner was sampled
    int          m_d      = -1;     // edge after which done is shown, -1 while pending

    always @(posedge clk) begin
        bit c_wr, c_rd;
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            m_last   = 1;
            m_addr   = '0;
            m_wdata  = '0;
            m_d      = -1;
        end else if (m_active) begin
            if (m_d >= 0) begin
                if (cyc == m_d + 1) begin
                    m_active = 1'b0;
                    m_last   = m_owner;
                end
            end else if (cyc >= m_g + 2 && i2c_end) begin
                m_d   = cyc;
                m_err = 1'b0;
                m_rsp = m_rd ? rd_data : 8'h00;
            end else if (cyc == m_g + TIMEOUT + 1) begin
                m_d   = cyc;
                m_err = 1'b1;
                m_rsp = 8'h00;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_owner = 1 - m_last;
            else              m_owner = req[1] ? 1 : 0;
            c_wr    = req_wr_en[m_owner];
            c_rd    = req_rd_en[m_owner];
            m_addr  = req_addr[m_owner*16 +: 16];
            m_wdata = req_wr_data[m_owner*8 +: 8];
            m_legal = c_wr | c_rd;
            m_wr    = c_wr;
            m_rd    = c_rd & ~c_wr;
            m_g     = cyc;
            m_d     = m_legal ? -1 : cyc;
            m_err   = ~m_legal;
            m_rsp   = 8'h00;
            m_active = 1'b1;
        end
    end

    // Compare every cycle, away from the sampling edge.
    always @(negedge clk) begin
        logic [1:0] e_grant, e_done;
        if (cmp_en) begin
            e_grant = m_active ? (2'b01 << m_owner) : 2'b00;
            e_done  = (m_active && m_d == cyc) ? e_grant : 2'b00;
            check("m_grant", grant, e_grant);
            check("m_i2c_start", i2c_start, m_active && m_legal && (m_g == cyc));
            check("m_done", done, e_done);
            check("m_wr_en", wr_en, m_active & m_wr);
            check("m_rd_en", rd_en, m_active & m_rd);
            if (m_active) begin
                check("m_byte_addr", byte_addr, m_addr);
                check("m_wr_data", wr_data, m_wdata);
            end
            if (e_done != 2'b00) begin
                check("m_err", err, m_err);
                check("m_rsp_data", rsp_data, m_rsp);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit auto_end    = 1'b0;   // master answers one cycle after i2c_start
    bit end_pending = 1'b0;

    // Advance one cycle; requesters drop req on their done, master auto-responds.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            if (done[i]) req[i] = 1'b0;
        if (auto_end) begin
            i2c_end     = end_pending;
            end_pending = i2c_start;
        end
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while (done == 2'b00 && n < max_cycles) begin
            step();
            n++;
        end
        if (done == 2'b00) check({name, "_wait_done"}, 32'd0, 32'd1);
    endtask

    task automatic collect_order(input int max_cycles, output logic [1:0] first,
                                 output logic [1:0] second);
        int n = 0;
        int got = 0;
        first  = 2'b00;
        second = 2'b00;
        while (got < 2 && n < max_cycles) begin
            step();
            n++;
            if (done != 2'b00) begin
                if (got == 0) first = done;
                else          second = done;
                got++;
            end
        end
    endtask

    task automatic rand_cmd(input int i);
        int c = $urandom_range(0, 7);
        req_wr_en[i] = (c == 1) || (c >= 2 && c <= 4);
        req_rd_en[i] = (c == 1) || (c >= 5);
        req_addr[i*16 +: 16]  = 16'($urandom);
        req_wr_data[i*8 +: 8] = 8'($urandom);
    endtask

    initial begin
        logic [1:0] o1, o2, req_before;
        int n;

        rst = 1'b1; req = '0; req_wr_en = '0; req_rd_en = '0;
        req_addr = '0; req_wr_data = '0; i2c_end = 1'b0; rd_data = '0;

        // Reset state.
        step();
        cmp_en = 1'b1;
        step(); step();
        check("rst_grant", grant, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_start", i2c_start, 1'b0);
        check("rst_wr_rd", {wr_en, rd_en}, 2'b00);
        check("rst_addr_data", {byte_addr, wr_data, rsp_data}, 32'h0);
        rst = 1'b0;
        step();

        // Single read by requester 0.
        req_wr_en = 2'b00; req_rd_en = 2'b01; req_addr[15:0] = 16'h0002; req = 2'b01;
        step();
        check("rd_start", i2c_start, 1'b1);
        check("rd_grant", grant, 2'b01);
        check("rd_addr", byte_addr, 16'h0002);
        check("rd_rd_en", {wr_en, rd_en}, 2'b01);
        step();
        check("rd_start_once", i2c_start, 1'b0);
        rd_data = 8'h59; i2c_end = 1'b1;
        step();
        i2c_end = 1'b0;
        check("rd_done", done, 2'b01);
        check("rd_err", err, 1'b0);
        check("rd_rsp", rsp_data, 8'h59);
        step();
        check("rd_release", grant, 2'b00);

        // Illegal command on requester 1.
        req_wr_en = 2'b00; req_rd_en = 2'b00; req_addr[31:16] = 16'h1234; req = 2'b10;
        step();
        check("ill_start", i2c_start, 1'b0);
        check("ill_done", done, 2'b10);
        check("ill_err", err, 1'b1);
        step(); step();
        check("ill_release", grant, 2'b00);

        // Timeout: no i2c_end at all.
        req_wr_en = 2'b01; req_rd_en = 2'b00; req_addr[15:0] = 16'h0010;
        req_wr_data[7:0] = 8'h3C; req = 2'b01;
        step();
        check("to_start", i2c_start, 1'b1);
        n = 0;
        while (done == 2'b00 && n < TIMEOUT + 8) begin
            step();
            n++;
        end
        check("to_busy_cycles", n - 1, TIMEOUT);
        check("to_done", done, 2'b01);
        check("to_err", err, 1'b1);
        check("to_rsp", rsp_data, 8'h00);
        step(); step();

        // Owner's inputs change during BUSY; the latched command must not.
        req_wr_en = 2'b01; req_rd_en = 2'b00; req_addr[15:0] = 16'h0008;
        req_wr_data[7:0] = 8'h77; req = 2'b01;
        step();
        check("stb_addr_issue", byte_addr, 16'h0008);
        req_addr[15:0] = 16'h00FF; req_wr_data[7:0] = 8'hEE;
        repeat (4) step();
        check("stb_addr_busy", byte_addr, 16'h0008);
        check("stb_data_busy", wr_data, 8'h77);
        rd_data = 8'hAB; i2c_end = 1'b1;
        step();
        i2c_end = 1'b0;
        check("stb_done", done, 2'b01);
        check("stb_addr_done", byte_addr, 16'h0008);
        check("stb_wr_rsp", rsp_data, 8'h00);
        step(); step();

        // Reset in the middle of BUSY, then a stray i2c_end.
        req_wr_en = 2'b00; req_rd_en = 2'b01; req_addr[15:0] = 16'h0040; req = 2'b01;
        step(); step(); step();
        rst = 1'b1; req = 2'b00;
        step();
        rst = 1'b0; rd_data = 8'h11; i2c_end = 1'b1;
        step();
        i2c_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstb_outputs", {grant, done, err, i2c_start, wr_en, rd_en}, 8'h00);
            check("rstb_data", {byte_addr, wr_data, rsp_data}, 32'h0);
            step();
        end
        auto_end = 1'b1;
        req_addr[15:0] = 16'h0004; rd_data = 8'h5A; req = 2'b01;
        step();
        check("rstb_next_start", i2c_start, 1'b1);
        check("rstb_next_addr", byte_addr, 16'h0004);
        wait_done("rstb_next", 10);
        check("rstb_next_done", done, 2'b01);
        check("rstb_next_rsp", rsp_data, 8'h5A);
        step(); step();

        // Simultaneous requests straight after reset: 0 then 1.
        rst = 1'b1; step(); rst = 1'b0; step();
        req_wr_en = 2'b00; req_rd_en = 2'b11; req_addr = 32'h0200_0100; req = 2'b11;
        collect_order(40, o1, o2);
        check("rr_first", o1, 2'b01);
        check("rr_second", o2, 2'b10);
        step(); step();
        // Requester 0 alone, then contention again: now 1 then 0.
        req = 2'b01;
        wait_done("rr_single", 10);
        step(); step();
        req = 2'b11;
        collect_order(40, o1, o2);
        check("rr_third", o1, 2'b10);
        check("rr_fourth", o2, 2'b01);
        step(); step();

        // Randomized traffic against the model.
        auto_end = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            req_before = req;
            step();
            rst     = ($urandom_range(0, 399) == 0);
            i2c_end = ($urandom_range(0, 7) == 0);
            rd_data = 8'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && !req_before[i]) begin
                    rand_cmd(i);
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end else if (req[i] && m_active && m_owner == i && $urandom_range(0, 1) == 1) begin
                    rand_cmd(i);
                end
            end
        end
        rst = 1'b0; i2c_end = 1'b0; req = 2'b00;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
